// File: rtl/traffic_light_pkg.sv
// Shared phase codes, fault codes and lamp decoding for the traffic light monitor.
package traffic_light_pkg;

  // Monitor state codes, also presented on the phase output.
  typedef enum logic [2:0] {
    PhIdle   = 3'd0,
    PhRed    = 3'd1,
    PhGreen  = 3'd2,
    PhYellow = 3'd3,
    PhFault  = 3'd4
  } phase_e;

  // Classification of one lamp sample.
  typedef enum logic [1:0] {
    LampDark,
    LampValid,
    LampConflict
  } lamp_class_e;

  localparam logic [2:0] FaultNone     = 3'd0;
  localparam logic [2:0] FaultConflict = 3'd1;
  localparam logic [2:0] FaultDark     = 3'd2;
  localparam logic [2:0] FaultIllegal  = 3'd3;
  localparam logic [2:0] FaultShort    = 3'd4;
  localparam logic [2:0] FaultLong     = 3'd5;

  // One-hot is a valid lamp, all-zero is dark, anything else is a conflict.
  function automatic lamp_class_e lamp_class(input logic red, input logic yellow,
                                             input logic green);
    lamp_class_e c;
    case ({red, yellow, green})
      3'b000:                 c = LampDark;
      3'b001, 3'b010, 3'b100: c = LampValid;
      default:                c = LampConflict;
    endcase
    return c;
  endfunction

  // Phase a valid (one-hot) lamp sample stands for; only meaningful for valid samples.
  function automatic phase_e lamp_to_phase(input logic red, input logic yellow,
                                           input logic green);
    phase_e p;
    if (red)         p = PhRed;
    else if (green)  p = PhGreen;
    else if (yellow) p = PhYellow;
    else             p = PhIdle;
    return p;
  endfunction

  // The only legal successor of each lamp phase.
  function automatic phase_e next_phase(input phase_e cur);
    phase_e p;
    case (cur)
      PhRed:    p = PhGreen;
      PhGreen:  p = PhYellow;
      PhYellow: p = PhRed;
      default:  p = PhIdle;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/traffic_dwell_counter.sv
// Dwell counter: clear, load-1, saturating increment, otherwise frozen.
module traffic_dwell_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Clear beats load beats increment; no request holds the value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(1);
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: checks R->G->Y->R order and per-phase dwell limits.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_red,
  input  logic             i_yellow,
  input  logic             i_green,
  input  logic             i_clr_fault,
  output logic [2:0]       o_phase,
  output logic [CNT_W-1:0] o_dwell,
  output logic             o_fault,
  output logic [2:0]       o_fault_code,
  output logic             o_cycle_done,
  output logic [15:0]      o_cycle_cnt
);

  localparam logic [CNT_W-1:0] MinDwellC = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] MaxDwellC = CNT_W'(MAX_DWELL);

  phase_e      r_state, w_state_d;
  logic        r_fault, w_fault_d;
  logic [2:0]  r_code, w_code_d;
  logic        r_done, w_done_d;
  logic [15:0] r_cnt, w_cnt_d;
  // Set while in the first phase after IDLE; that phase is exempt from the too-short check.
  logic        r_first, w_first_d;

  logic             w_dw_clr, w_dw_load, w_dw_inc;
  logic [CNT_W-1:0] w_dwell;
  lamp_class_e      w_class;
  phase_e           w_lamp;

  assign w_class = lamp_class(i_red, i_yellow, i_green);
  assign w_lamp  = lamp_to_phase(i_red, i_yellow, i_green);

  traffic_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_dw_clr),
    .i_load  (w_dw_load),
    .i_inc   (w_dw_inc),
    .o_count (w_dwell)
  );

  // Next-state decode: clear first, then classify the sample against the current phase.
  always_comb begin
    w_state_d = r_state;
    w_fault_d = r_fault;
    w_code_d  = r_code;
    w_done_d  = 1'b0;
    w_cnt_d   = r_cnt;
    w_first_d = r_first;
    w_dw_clr  = 1'b0;
    w_dw_load = 1'b0;
    w_dw_inc  = 1'b0;

    if (i_clr_fault) begin
      w_state_d = PhIdle;
      w_fault_d = 1'b0;
      w_code_d  = FaultNone;
      w_first_d = 1'b0;
      w_dw_clr  = 1'b1;
    end else begin
      unique case (r_state)
        PhIdle: begin
          if (w_class == LampConflict) begin
            w_state_d = PhFault;
            w_fault_d = 1'b1;
            w_code_d  = FaultConflict;
          end else if ((w_class == LampValid) && (w_lamp == PhRed)) begin
            w_state_d = PhRed;
            w_first_d = 1'b1;
            w_dw_load = 1'b1;
          end
        end
        PhRed, PhGreen, PhYellow: begin
          if (w_class == LampConflict) begin
            w_state_d = PhFault;
            w_fault_d = 1'b1;
            w_code_d  = FaultConflict;
          end else if (w_class == LampDark) begin
            w_state_d = PhFault;
            w_fault_d = 1'b1;
            w_code_d  = FaultDark;
          end else if (w_lamp == r_state) begin
            if (w_dwell == MaxDwellC) begin
              w_state_d = PhFault;
              w_fault_d = 1'b1;
              w_code_d  = FaultLong;
            end else begin
              w_dw_inc = 1'b1;
            end
          end else if (w_lamp == next_phase(r_state)) begin
            if (!r_first && (w_dwell < MinDwellC)) begin
              w_state_d = PhFault;
              w_fault_d = 1'b1;
              w_code_d  = FaultShort;
            end else begin
              w_state_d = w_lamp;
              w_first_d = 1'b0;
              w_dw_load = 1'b1;
              if (r_state == PhYellow) begin
                w_done_d = 1'b1;
                w_cnt_d  = r_cnt + 16'd1;
              end
            end
          end else begin
            w_state_d = PhFault;
            w_fault_d = 1'b1;
            w_code_d  = FaultIllegal;
          end
        end
        PhFault: begin
          // Sticky until clr_fault or reset; samples ignored, dwell frozen.
        end
        default: begin
          w_state_d = PhIdle;
        end
      endcase
    end
  end

  // Monitor FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PhIdle;
      r_fault <= 1'b0;
      r_code  <= FaultNone;
      r_done  <= 1'b0;
      r_cnt   <= 16'd0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_fault <= w_fault_d;
      r_code  <= w_code_d;
      r_done  <= w_done_d;
      r_cnt   <= w_cnt_d;
      r_first <= w_first_d;
    end
  end

  assign o_phase      = r_state;
  assign o_dwell      = w_dwell;
  assign o_fault      = r_fault;
  assign o_fault_code = r_code;
  assign o_cycle_done = r_done;
  assign o_cycle_cnt  = r_cnt;

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter MIN_DWELL, 1, minimum legal consecutive samples per phase.
REQ-002 Parameter MAX_DWELL, 4, maximum legal consecutive samples per phase.
REQ-003 Parameter CNT_W, 8, dwell counter width; MAX_DWELL SHALL be < 2^CNT_W.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 red  input  1  observed red lamp, synchronous to clk.
REQ-007 yellow  input  1  observed yellow lamp, synchronous to clk.
REQ-008 green  input  1  observed green lamp, synchronous to clk.
REQ-009 clr_fault  input  1  single-cycle pulse, clears sticky fault.
REQ-010 phase  output  3  current monitor state code.
REQ-011 dwell  output  CNT_W  consecutive samples of current phase.
REQ-012 fault  output  1  sticky fault flag.
REQ-013 fault_code  output  3  cause of first fault.
REQ-014 cycle_done  output  1  one-cycle pulse per completed RED-GREEN-YELLOW cycle.
REQ-015 cycle_cnt  output  16  completed cycle count, wraps 0xFFFF->0.

Function
REQ-016 Lamps SHALL be sampled at each rising edge with no input register; outputs SHALL reflect that sample immediately after the same edge.
REQ-017 Sample classes: one-hot = valid lamp; all-zero = dark; more than one set = conflict.
REQ-018 FSM states, in codes: IDLE=0, RED=1, GREEN=2, YELLOW=3, FAULT=4.
REQ-019 IDLE: RED sample -> RED with dwell=1; GREEN, YELLOW or dark -> stay IDLE, no fault; conflict -> FAULT.
REQ-020 Legal transitions only RED->GREEN, GREEN->YELLOW, YELLOW->RED; same lamp again -> stay with dwell+1, saturating at 2^CNT_W-1.
REQ-021 On a legal transition, dwell SHALL load 1.
REQ-022 Fault codes: 1 conflict, 2 dark, 3 illegal transition, 4 dwell too short, 5 dwell too long; 0 = none.
REQ-023 In RED/GREEN/YELLOW, fault priority per sample SHALL be conflict > dark > illegal transition > too short > too long.
REQ-024 Too short: legal transition taken while dwell < MIN_DWELL; the first phase entered from IDLE is exempt.
REQ-025 Too long: same lamp sampled while dwell == MAX_DWELL.
REQ-026 On a fault: state -> FAULT, fault=1, fault_code latched, dwell frozen; further samples ignored.
REQ-027 clr_fault in any state SHALL force IDLE, fault=0, fault_code=0, dwell=0 on that edge, taking priority over that cycle's sample; cycle_cnt is preserved.
REQ-028 A legal YELLOW->RED transition SHALL pulse cycle_done for one cycle and increment cycle_cnt on the same edge.
REQ-029 cycle_done SHALL be 0 in all other cycles, including the IDLE->RED sync.

Reset
REQ-030 rst_n low SHALL immediately force phase=IDLE, dwell=0, fault=0, fault_code=0, cycle_done=0, cycle_cnt=0.
REQ-031 Reset mid-phase or in FAULT SHALL discard all history; the first post-reset cycle starts from IDLE.
REQ-032 Deassertion SHALL be taken only as synchronous to clk; no other reset path exists.

Structure
REQ-033 Shared package traffic_light_pkg SHALL hold the phase codes, the fault-code constants and the lamp-to-phase mapping, shared with the controller.
REQ-034 One sub-module, traffic_dwell_counter, SHALL implement the load-1, increment, saturate and freeze counter, with CNT_W as its parameter.
REQ-035 Estimated RTL size: 150-250 lines.

Verification
REQ-036 Reset, then R,G,Y,R,G,Y,R at one sample each with default parameters -> phases 1,2,3,1,2,3,1; two cycle_done pulses; cycle_cnt=2; fault=0.
REQ-037 In GREEN, drive red=1 and green=1 -> next edge fault=1, fault_code=1, phase=4; clr_fault pulse -> phase=0, fault_code=0.
REQ-038 In RED, drive YELLOW -> fault_code=3; in GREEN, drive all-zero -> fault_code=2.
REQ-039 MAX_DWELL=4: RED held for 5 samples -> dwell 1..4, then fault_code=5 on the 5th edge; MIN_DWELL=2: R,R,G,Y -> fault_code=4 at Y.
REQ-040 Assert rst_n low mid-GREEN with cycle_cnt=3 -> all outputs zero immediately; clr_fault coincident with a conflict sample -> IDLE, fault=0.
